// File: rtl/fpu_bus_slave.sv
// CPU-side register port of the FPU: synchronizes the async bus strobes, assembles
// byte-wide operands, launches the core and exposes its result and completion handshake.
module fpu_bus_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int OP_W        = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [7:0]      databus_in,
  output logic [7:0]      databus_out,
  input  logic [3:0]      addr,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic            end_ack,
  output logic            cmd_end,
  output logic            busy,
  output logic            core_start,
  output logic [OP_W-1:0] core_op,
  output logic [31:0]     core_a,
  output logic [31:0]     core_b,
  input  logic            core_done,
  input  logic [31:0]     core_result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DONE    = 3'd2,
    S_ACKWAIT = 3'd3
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, ack_sync_q, ack_sync_d;
  logic                   wr_prev_q, wr_prev_d;
  logic [3:0]             shadow_addr_q, shadow_addr_d;
  logic [7:0]             shadow_data_q, shadow_data_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic [31:0]            core_a_q, core_a_d, core_b_q, core_b_d;
  logic [31:0]            result_q, result_d;
  logic [OP_W-1:0]        op_q, op_d;
  state_e                 state_q, state_d;
  logic                   busy_q, busy_d, cmd_end_q, cmd_end_d;
  logic                   err_q, err_d, start_q, start_d;

  logic       cs_s, wr_s, rd_s, ack_s;
  logic       capture_s, commit_s, launch_s;
  logic [7:0] status_s, rd_data_s;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign wr_s  = wr_sync_q[SYNC_STAGES-1];
  assign rd_s  = rd_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Shadow capture only during a clean write cycle; rd and wr never overlap on a legal bus.
  assign capture_s = !cs_s && !wr_s && rd_s;
  assign commit_s  = !cs_s && !wr_prev_q && wr_s;
  assign launch_s  = commit_s && (shadow_addr_q == 4'h8);

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
    wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], wr};
    rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], rd};
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], end_ack};
    wr_prev_d  = wr_s;

    shadow_addr_d = shadow_addr_q;
    shadow_data_d = shadow_data_q;
    a_d        = a_q;
    b_d        = b_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    result_d   = result_q;
    op_d       = op_q;
    state_d    = state_q;
    busy_d     = busy_q;
    cmd_end_d  = cmd_end_q;
    err_d      = err_q;
    start_d    = 1'b0;

    if (capture_s) begin
      shadow_addr_d = addr;
      shadow_data_d = databus_in;
    end else begin
      shadow_addr_d = shadow_addr_q;
    end

    if (commit_s && (shadow_addr_q[3:2] == 2'b00)) begin
      a_d[{shadow_addr_q[1:0], 3'b000} +: 8] = shadow_data_q;
    end else if (commit_s && (shadow_addr_q[3:2] == 2'b01)) begin
      b_d[{shadow_addr_q[1:0], 3'b000} +: 8] = shadow_data_q;
    end else begin
      a_d = a_q;
    end

    if (launch_s && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          op_d     = shadow_data_q[OP_W-1:0];
          core_a_d = a_q;
          core_b_d = b_q;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (core_done) begin
          result_d  = core_result;
          busy_d    = 1'b0;
          cmd_end_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (ack_s) begin
          cmd_end_d = 1'b0;
          state_d   = S_ACKWAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ACKWAIT: begin
        if (!ack_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACKWAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, register file and synchronizer flops; idle strobe levels are high.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      wr_sync_q     <= {SYNC_STAGES{1'b1}};
      rd_sync_q     <= {SYNC_STAGES{1'b1}};
      ack_sync_q    <= {SYNC_STAGES{1'b0}};
      wr_prev_q     <= 1'b1;
      shadow_addr_q <= 4'h0;
      shadow_data_q <= 8'h00;
      a_q           <= 32'h0;
      b_q           <= 32'h0;
      core_a_q      <= 32'h0;
      core_b_q      <= 32'h0;
      result_q      <= 32'h0;
      op_q          <= '0;
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      cmd_end_q     <= 1'b0;
      err_q         <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      wr_sync_q     <= wr_sync_d;
      rd_sync_q     <= rd_sync_d;
      ack_sync_q    <= ack_sync_d;
      wr_prev_q     <= wr_prev_d;
      shadow_addr_q <= shadow_addr_d;
      shadow_data_q <= shadow_data_d;
      a_q           <= a_d;
      b_q           <= b_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      result_q      <= result_d;
      op_q          <= op_d;
      state_q       <= state_d;
      busy_q        <= busy_d;
      cmd_end_q     <= cmd_end_d;
      err_q         <= err_d;
      start_q       <= start_d;
    end
  end

  assign status_s = {busy_q, cmd_end_q, err_q, 2'b00, state_q};

  // Readback decodes the raw bus address so the CPU sees data within its rd strobe.
  always_comb begin
    rd_data_s = 8'h00;
    case (addr)
      4'h0:    rd_data_s = a_q[7:0];
      4'h1:    rd_data_s = a_q[15:8];
      4'h2:    rd_data_s = a_q[23:16];
      4'h3:    rd_data_s = a_q[31:24];
      4'h4:    rd_data_s = b_q[7:0];
      4'h5:    rd_data_s = b_q[15:8];
      4'h6:    rd_data_s = b_q[23:16];
      4'h7:    rd_data_s = b_q[31:24];
      4'h9:    rd_data_s = result_q[7:0];
      4'hA:    rd_data_s = result_q[15:8];
      4'hB:    rd_data_s = result_q[23:16];
      4'hC:    rd_data_s = result_q[31:24];
      4'hD:    rd_data_s = status_s;
      default: rd_data_s = 8'h00;
    endcase
  end

  assign databus_out = (!cs && !rd) ? rd_data_s : 8'h00;
  assign cmd_end     = cmd_end_q;
  assign busy        = busy_q;
  assign core_start  = start_q;
  assign core_op     = op_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;

endmodule

// File: tb/tb_fpu_bus_slave.sv
// Directed test of fpu_bus_slave: operand load/readback, launch, completion handshake,
// busy-time error handling, back-to-back operations and reset while running.
module tb_fpu_bus_slave;
  localparam int SS   = 2;
  localparam int OP_W = 8;

  logic            clk = 1'b0;
  logic            arst;
  logic [7:0]      databus_in, databus_out;
  logic [3:0]      addr;
  logic            cs, rd, wr, end_ack;
  logic            cmd_end, busy, core_start;
  logic [OP_W-1:0] core_op;
  logic [31:0]     core_a, core_b;
  logic            core_done;
  logic [31:0]     core_result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = -1;
  int wr_rise_cyc = 0;

  fpu_bus_slave #(.SYNC_STAGES(SS), .OP_W(OP_W)) dut (
    .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
    .busy(busy), .core_start(core_start), .core_op(core_op), .core_a(core_a),
    .core_b(core_b), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    repeat (4) @(negedge clk);
    wr = 1'b1; wr_rise_cyc = cyc;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    #1 rd = 1'b1; cs = 1'b1;
  endtask

  task automatic core_finish(input logic [31:0] r);
    @(negedge clk);
    core_done = 1'b1; core_result = r;
    @(negedge clk);
    core_done = 1'b0; core_result = 32'h0;
  endtask

  task automatic ack_cycle();
    @(negedge clk); end_ack = 1'b1;
    repeat (5) @(negedge clk);
    end_ack = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    arst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({cmd_end, busy, core_start} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {cmd_end, busy, core_start}); end
    checks++; if (core_op !== 8'h00 || core_a !== 32'h0 || core_b !== 32'h0) begin errors++; $display("FAIL reset_core got op=%h a=%h b=%h exp zeros", core_op, core_a, core_b); end
    arst = 1'b1;
    bus_read(4'hD, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", d); end
  endtask

  task automatic test_operand_rw();
    logic [7:0] d;
    logic [31:0] a_val = 32'h43a9ab64;
    logic [31:0] b_val = 32'hc479fff0;
    for (int i = 0; i < 4; i++) bus_write(4'(i), a_val[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_write(4'(i + 4), b_val[8*i +: 8]);
    for (int i = 0; i < 8; i++) begin
      bus_read(4'(i), d);
      checks++;
      if (d !== (i < 4 ? a_val[8*i +: 8] : b_val[8*(i-4) +: 8])) begin errors++; $display("FAIL opnd_rd%0d got %h", i, d); end
    end
    checks++; if ({busy, cmd_end} !== 2'b00) begin errors++; $display("FAIL idle_flags got %b exp 00", {busy, cmd_end}); end
    bus_read(4'hE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reserved_rd got %h exp 00", d); end
    @(negedge clk); addr = 4'h0; cs = 1'b1; rd = 1'b0;
    #1; checks++; if (databus_out !== 8'h00) begin errors++; $display("FAIL rd_no_cs got %h exp 00", databus_out); end
    rd = 1'b1;
  endtask

  task automatic test_launch();
    logic [7:0] d;
    int n0 = start_cnt;
    bus_write(4'h8, 8'h01);
    repeat (3) @(negedge clk);
    checks++; if (start_cnt !== n0 + 1) begin errors++; $display("FAIL start_pulses got %0d exp %0d", start_cnt - n0, 1); end
    checks++; if (start_cyc - wr_rise_cyc > SS + 2 || start_cyc < wr_rise_cyc) begin errors++; $display("FAIL start_latency got %0d exp <=%0d", start_cyc - wr_rise_cyc, SS + 2); end
    checks++; if (core_op !== 8'h01 || core_a !== 32'h43a9ab64 || core_b !== 32'hc479fff0) begin errors++; $display("FAIL launch_core got op=%h a=%h b=%h", core_op, core_a, core_b); end
    bus_read(4'hD, d);
    checks++; if (d !== 8'h81 || busy !== 1'b1) begin errors++; $display("FAIL run_status got %h busy=%b exp 81", d, busy); end
  endtask

  task automatic test_done();
    logic [7:0] d;
    logic [31:0] r = 32'hc4252a3d;
    core_finish(r);
    checks++; if ({cmd_end, busy} !== 2'b10) begin errors++; $display("FAIL done_flags got %b exp 10", {cmd_end, busy}); end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i + 9), d);
      checks++; if (d !== r[8*i +: 8]) begin errors++; $display("FAIL result_rd%0d got %h exp %h", i, d, r[8*i +: 8]); end
    end
    bus_read(4'hD, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL done_status got %h exp 42", d); end
  endtask

  task automatic test_ack();
    logic [7:0] d;
    int waited = 0;
    int n0;
    @(negedge clk); end_ack = 1'b1;
    while (cmd_end === 1'b1 && waited < 10) begin @(negedge clk); waited++; end
    checks++; if (cmd_end !== 1'b0 || waited > SS + 1) begin errors++; $display("FAIL ack_latency got %0d cmd_end=%b exp <=%0d", waited, cmd_end, SS + 1); end
    bus_read(4'hD, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL ackwait_status got %h exp 03", d); end
    end_ack = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(4'hD, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL idle_status got %h exp 00", d); end
    n0 = start_cnt;
    bus_write(4'h8, 8'h05);
    repeat (3) @(negedge clk);
    checks++; if (start_cnt !== n0 + 1 || core_op !== 8'h05 || busy !== 1'b1) begin errors++; $display("FAIL second_op got starts=%0d op=%h busy=%b exp 1 05 1", start_cnt - n0, core_op, busy); end
    core_finish(32'h0000_00aa);
    ack_cycle();
  endtask

  task automatic test_err_while_busy();
    logic [7:0] d;
    logic [31:0] r = 32'h12345678;
    int n0 = start_cnt;
    bus_write(4'h8, 8'h01);
    bus_write(4'h0, 8'h11);
    bus_write(4'h8, 8'h02);
    repeat (3) @(negedge clk);
    checks++; if (start_cnt !== n0 + 1) begin errors++; $display("FAIL busy_starts got %0d exp 1", start_cnt - n0); end
    checks++; if (core_op !== 8'h01 || core_a !== 32'h43a9ab64) begin errors++; $display("FAIL busy_snapshot got op=%h a=%h exp 01 43a9ab64", core_op, core_a); end
    bus_read(4'hD, d);
    checks++; if (d !== 8'hA1) begin errors++; $display("FAIL err_status got %h exp a1", d); end
    bus_read(4'h0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL busy_wr_a0 got %h exp 11", d); end
    core_finish(r);
    checks++; if ({cmd_end, busy} !== 2'b10) begin errors++; $display("FAIL err_done_flags got %b exp 10", {cmd_end, busy}); end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i + 9), d);
      checks++; if (d !== r[8*i +: 8]) begin errors++; $display("FAIL err_result%0d got %h exp %h", i, d, r[8*i +: 8]); end
    end
    bus_read(4'hD, d);
    checks++; if (d !== 8'h62) begin errors++; $display("FAIL err_done_status got %h exp 62", d); end
    ack_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int n0 = start_cnt;
    bus_write(4'h8, 8'h03);
    bus_read(4'hD, d);
    checks++; if (d !== 8'h81 || core_a !== 32'h43a9ab11) begin errors++; $display("FAIL b2b_first got status=%h a=%h exp 81 43a9ab11", d, core_a); end
    core_finish(32'h0);
    ack_cycle();
    bus_write(4'h8, 8'h04);
    repeat (3) @(negedge clk);
    checks++; if (start_cnt !== n0 + 2 || core_op !== 8'h04) begin errors++; $display("FAIL b2b_second got starts=%0d op=%h exp 2 04", start_cnt - n0, core_op); end
  endtask

  task automatic test_reset_in_run();
    logic [7:0] d;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
    #2 arst = 1'b0;
    #1; checks++; if ({busy, cmd_end, core_start} !== 3'b000 || core_op !== 8'h00 || core_a !== 32'h0 || core_b !== 32'h0) begin errors++; $display("FAIL async_reset got flags=%b op=%h a=%h b=%h", {busy, cmd_end, core_start}, core_op, core_a, core_b); end
    @(negedge clk); arst = 1'b1;
    core_finish(32'hdeadbeef);
    repeat (2) @(negedge clk);
    checks++; if ({cmd_end, busy} !== 2'b00) begin errors++; $display("FAIL post_reset_done got %b exp 00", {cmd_end, busy}); end
    bus_read(4'hD, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_status got %h exp 00", d); end
    bus_read(4'h9, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_result got %h exp 00", d); end
    bus_read(4'h0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_a0 got %h exp 00", d); end
  endtask

  initial begin
    arst = 1'b0; databus_in = 8'h00; addr = 4'h0;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
    core_done = 1'b0; core_result = 32'h0;
    test_reset();
    test_operand_rw();
    test_launch();
    test_done();
    test_ack();
    test_err_while_busy();
    test_back_to_back();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_bus_slave.md
Name: fpu_bus_slave

Overview:
- Responder side of the FPU's 8-bit CPU register port.
- Decodes chip-select, read and write strobes, which are active-low and asynchronous to clk.
- Assembles the 32-bit operands A and B byte by byte, launches the FPU core when the operation register is written, and holds the core result for byte-wise readback.
- Implements the cmd_end / end_ack completion handshake. Sits between the CPU bus and the FPU arithmetic core.

Parameters:
- SYNC_STAGES, 2, number of flops in the cs/rd/wr/end_ack synchronizers (minimum 2).
- OP_W, 8, width of the operation code passed to the core.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-low.
- databus_in  in  8  CPU write data.
- databus_out  out  8  CPU read data.
- addr  in  4  register address.
- cs  in  1  chip select, active-low.
- rd  in  1  read strobe, active-low.
- wr  in  1  write strobe, active-low; a write commits on the rising edge of wr.
- end_ack  in  1  CPU acknowledge of completion, level.
- cmd_end  out  1  completion flag / irq, high until acknowledged.
- busy  out  1  high while an operation is running.
- core_start  out  1  one-cycle launch pulse to the core.
- core_op  out  OP_W  operation code, stable from core_start until core_done.
- core_a  out  32  operand A.
- core_b  out  32  operand B.
- core_done  in  1  one-cycle completion pulse from the core.
- core_result  in  32  result, valid in the core_done cycle.

Behaviour:
- Reset (arst=0, async):
  - operand, op and result registers clear to 0.
  - cmd_end=0, busy=0, core_start=0, databus_out=0, err=0.
  - FSM goes to IDLE; any in-flight core_done is ignored.
- Strobe synchronization:
  - cs, wr, rd and end_ack each pass through a SYNC_STAGES synchronizer.
  - While synced cs=0 and synced wr=0, addr and databus_in are captured every clk into a shadow register.
  - A write commits in the cycle the synced wr goes 0->1 with synced cs=0, using the shadow contents.
  - Latency from the bus wr rising edge to commit is SYNC_STAGES+1 clk at most.
- Address map:
  - 0-3: A bytes, LSB first.
  - 4-7: B bytes, LSB first.
  - 8: op (write only, triggers launch).
  - 9-C: result bytes, LSB first.
  - D: status = {busy, cmd_end, err, 2'b0, fsm_state[2:0]}; bit 7 first.
  - E-F: reserved; writes are ignored, reads return 0.
- Reads:
  - databus_out = register selected by the raw addr, combinationally, when raw cs=0 and rd=0; otherwise 8'h00.
  - Operand registers 0-7 read back as written.
- FSM states: IDLE, RUN, DONE, ACKWAIT.
  - IDLE: a commit to addr 8 latches databus_in[OP_W-1:0] into core_op. In the next cycle core_start=1 for one cycle, busy goes 1, and the FSM goes to RUN.
  - RUN: on core_done, result is latched from core_result, busy goes 0, cmd_end goes 1 in the next cycle, and the FSM goes to DONE.
  - DONE: when synced end_ack=1, cmd_end goes 0 and the FSM goes to ACKWAIT.
  - ACKWAIT: when synced end_ack=0, the FSM goes to IDLE.
- Boundary cases:
  - A write to addr 8 in any state other than IDLE is ignored and sets err. err clears on the next accepted launch.
  - Writes to addr 0-7 while busy update the registers, but core_a and core_b are snapshotted at core_start, so a running operation is unaffected.
  - end_ack high in IDLE or RUN has no effect.
  - core_done in a state other than RUN is ignored.
  - core_done in the same cycle as a commit is handled independently; both take effect.
  - Back-to-back operations are legal once the FSM is in IDLE.

Test Plan:
- Write 32'h43a9ab64 to addr 0-3, then read addr 0-3 -> 64, ab, a9, 43; busy=0, cmd_end=0.
- Load A=43a9ab64, B=c479fff0, write op 8'h01 to addr 8 -> exactly one core_start pulse within SYNC_STAGES+2 clk of wr rising; core_op=01, core_a=43a9ab64, core_b=c479fff0; busy=1.
- Core returns core_done with core_result=32'hc4252a3d -> cmd_end=1 and busy=0 one clk later; reads of addr 9-C return 3d, 2a, 25, c4.
- Raise end_ack -> cmd_end falls within SYNC_STAGES+1 clk; lower end_ack -> status reads FSM=IDLE; a second operation launches normally.
- Write op 8'h02 while busy -> no core_start, status err bit=1; the original result still completes correctly.
- Pull arst low while in RUN, then release, then pulse core_done -> all outputs 0, cmd_end stays 0, status reads 8'h00.
